ps2_note_decoder: RTL
=====================

// Module: ps2_note_decoder
// PURPOSE
//  Downstream of the PS/2 keyboard controller. Consumes its received_data/received_data_en byte stream.
//  Parses set-2 make/break/extended sequences into a monophonic note gate for the synth voice.
//  Outputs: note index (A=0..G#=11), octave, gate and note-on strobe.
//  Tracks all 12 held keys; the last-pressed key has priority.
// PARAMETERS
//  OCT_DEFAULT     4          octave after reset (0..OCT_MAX)
//  OCT_MAX         7          highest octave; octave saturates at 0 and OCT_MAX
//  PREFIX_TIMEOUT  5_000_000  idle cycles (100 ms @50 MHz) in a prefix state before forced return to IDLE
// PORTS
//  CLOCK_50          in   1   system clock, 50 MHz
//  reset             in   1   asynchronous, active-low reset
//  received_data     in   8   scan code byte from PS/2 controller
//  received_data_en  in   1   1-cycle strobe: received_data valid
//  note              out  4   current note index 0..11 (A,A#,B,C,C#,D,D#,E,F,F#,G,G#)
//  octave            out  3   current octave 0..OCT_MAX
//  note_valid        out  1   gate: high while >=1 note key held
//  note_strobe       out  1   1-cycle pulse when note changes to a newly pressed key
//  key_held          out  12  bit i set while key for note i held
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE, note=0, octave=OCT_DEFAULT, note_valid=0, note_strobe=0, key_held=0.
//   Timeout counter clears.
//  Key map (make codes): 1C=0 1D=1 1B=2 23=3 2D=4 2B=5 2C=6 34=7 33=8 3C=9 3B=10 43=11.
//   1A=octave down, 22=octave up. All other codes ignored.
//  FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). Transitions fire only on received_data_en.
//   IDLE: F0->BRK; E0->EXT; other code = make event.
//   BRK: any code = break event, ->IDLE.
//   EXT: F0->EXT_BRK; other code ignored, ->IDLE.
//   EXT_BRK: any code ignored, ->IDLE.
//   Extended keys therefore never alter note state.
//  Make of note key i, not already held: set key_held[i], note<=i, note_valid<=1, note_strobe=1 next cycle.
//  Make of a held key (typematic repeat): no change, no strobe.
//  Break of key i: clear key_held[i]. Held-set handling after the clear:
//   - set empty: note_valid<=0 and note holds its value.
//   - i was the current note and others remain held: note<=lowest-index remaining bit, note_strobe=1.
//   - otherwise: no change.
//  Octave keys act on make only. Decrement at 0 and increment at OCT_MAX are no-ops.
//   note_valid and note are unaffected. Octave keys do not strobe.
//  Latency: all outputs update on the CLOCK_50 edge after the edge that samples received_data_en=1.
//   note_strobe is high exactly 1 cycle.
//  Timeout: counter runs only in BRK/EXT/EXT_BRK and resets on each received_data_en.
//   At PREFIX_TIMEOUT it forces IDLE with no event.
//   If a byte arrives in the same cycle the timeout expires, the byte is processed in the current state.
//  Break of an unmapped or not-held code: no effect.
//  Async reset mid-sequence abandons the sequence; the next byte is parsed from IDLE.
// CONFIGURATION
//  NOTE_RETRIGGER_EN defined: make of an already-held key re-asserts note<=i and pulses note_strobe
//   (typematic repeat retriggers the envelope).
//  NOTE_RETRIGGER_EN undefined: repeats ignored as above.
// TESTING
//  T1 reset -> note=0, octave=4, note_valid=0, key_held=000.
//  T2 byte 1C -> 1 cycle later: note=0, note_valid=1, 1-cycle note_strobe, key_held=001.
//     Then F0,1C -> note_valid=0, key_held=000.
//  T3 make 1C, make 2B -> note=5, 2 strobes.
//     F0,2B -> note=0, strobe, note_valid=1.
//     F0,1C -> note_valid=0, no strobe.
//  T4 E0,1C -> no change. E0,F0,1C while 1C held -> 1C remains held.
//  T5 22 x5 -> octave=7 (saturates). 1A x9 -> octave=0.
//  T6 F0 then no byte for PREFIX_TIMEOUT cycles, then 1D -> treated as make: note=1, strobe.
//  T7 1C,1C: one strobe without NOTE_RETRIGGER_EN, two strobes with it.

Source files
------------

// File: rtl/ps2_note_decoder.sv
// PS/2 set-2 scan-code parser driving a monophonic note gate with last-pressed priority.
// Optional NOTE_RETRIGGER_EN: typematic repeats of a held key re-assert the note and strobe.
module ps2_note_decoder #(
  parameter int unsigned OCT_DEFAULT    = 4,
  parameter int unsigned OCT_MAX        = 7,
  parameter int unsigned PREFIX_TIMEOUT = 5_000_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  received_data,
  input  logic        received_data_en,
  output logic [3:0]  note,
  output logic [2:0]  octave,
  output logic        note_valid,
  output logic        note_strobe,
  output logic [11:0] key_held
);

  localparam int unsigned CntW = $clog2(PREFIX_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        note_q, note_d;
  logic [2:0]        octave_q, octave_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;
  logic [11:0]       held_q, held_d;

  logic              key_hit;
  logic [3:0]        key_idx;
  logic [11:0]       held_clr;
  logic [3:0]        lowest;

  // Returns {hit, index} for the twelve note keys.
  function automatic logic [4:0] decode_key(input logic [7:0] code);
    unique case (code)
      8'h1C:   decode_key = {1'b1, 4'd0};
      8'h1D:   decode_key = {1'b1, 4'd1};
      8'h1B:   decode_key = {1'b1, 4'd2};
      8'h23:   decode_key = {1'b1, 4'd3};
      8'h2D:   decode_key = {1'b1, 4'd4};
      8'h2B:   decode_key = {1'b1, 4'd5};
      8'h2C:   decode_key = {1'b1, 4'd6};
      8'h34:   decode_key = {1'b1, 4'd7};
      8'h33:   decode_key = {1'b1, 4'd8};
      8'h3C:   decode_key = {1'b1, 4'd9};
      8'h3B:   decode_key = {1'b1, 4'd10};
      8'h43:   decode_key = {1'b1, 4'd11};
      default: decode_key = {1'b0, 4'd0};
    endcase
  endfunction

  assign {key_hit, key_idx} = decode_key(received_data);
  assign held_clr = held_q & ~(12'b1 << key_idx);

  always_comb begin
    lowest = 4'd0;
    for (int i = 11; i >= 0; i--) begin
      if (held_clr[i]) lowest = 4'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    note_d   = note_q;
    octave_d = octave_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    held_d   = held_q;

    // A byte landing on the expiry cycle wins over the timeout.
    if (state_q == StIdle || received_data_en) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(PREFIX_TIMEOUT - 1)) begin
      cnt_d   = '0;
      state_d = StIdle;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (received_data_en) begin
      unique case (state_q)
        StIdle: begin
          if (received_data == 8'hF0) begin
            state_d = StBrk;
          end else if (received_data == 8'hE0) begin
            state_d = StExt;
          end else if (key_hit) begin
            if (!held_q[key_idx]) begin
              held_d[key_idx] = 1'b1;
              note_d          = key_idx;
              valid_d         = 1'b1;
              strobe_d        = 1'b1;
            end else begin
`ifdef NOTE_RETRIGGER_EN
              note_d   = key_idx;
              strobe_d = 1'b1;
`endif
            end
          end else if (received_data == 8'h22) begin
            if (octave_q < 3'(OCT_MAX)) octave_d = octave_q + 1'b1;
          end else if (received_data == 8'h1A) begin
            if (octave_q != 3'd0) octave_d = octave_q - 1'b1;
          end
        end
        StBrk: begin
          state_d = StIdle;
          if (key_hit && held_q[key_idx]) begin
            held_d = held_clr;
            if (held_clr == 12'd0) begin
              valid_d = 1'b0;
            end else if (note_q == key_idx) begin
              note_d   = lowest;
              strobe_d = 1'b1;
            end
          end
        end
        StExt: begin
          state_d = (received_data == 8'hF0) ? StExtBrk : StIdle;
        end
        StExtBrk: begin
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      note_q   <= 4'd0;
      octave_q <= 3'(OCT_DEFAULT);
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      held_q   <= 12'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      note_q   <= note_d;
      octave_q <= octave_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
    end
  end

  assign note        = note_q;
  assign octave      = octave_q;
  assign note_valid  = valid_q;
  assign note_strobe = strobe_q;
  assign key_held    = held_q;

endmodule
